// File: rtl/pci_cmd_control_if.sv
// Bus bundle for the PCI command decoder: initiator/target control lines in,
// latched command and storage strobes out.
interface pci_cmd_control_if;
  logic       Frame;
  logic       Irdy;
  logic       Devsel;
  logic [3:0] CBE;
  logic [1:0] rw;
  logic       RE;
  logic       WE;

  modport master (
    output Frame, Irdy, Devsel, CBE,
    input  rw, RE, WE
  );

  modport slave (
    input  Frame, Irdy, Devsel, CBE,
    output rw, RE, WE
  );
endinterface

// File: rtl/pci_cmd_control.sv
// PCI command decoder: latches the address-phase command and produces
// one-cycle read/write strobes for every claimed, ready data phase.
module pci_cmd_control (
  input  logic                Clock,
  input  logic                RST,
  pci_cmd_control_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    DATA   = 2'b01,
    IGNORE = 2'b10
  } state_t;

  state_t     state_reg, state_next;
  logic [1:0] rw_reg, rw_next;
  // Set once an idle bus edge has been seen; a transaction already under way
  // when reset releases must run to completion before a new one is accepted.
  logic       armed_reg, armed_next;
  logic       bus_idle;

  assign bus_idle = bus.Frame & bus.Irdy;

  always_ff @(posedge Clock) begin
    if (RST) begin
      state_reg <= IDLE;
      rw_reg    <= 2'b00;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      rw_reg    <= rw_next;
      armed_reg <= armed_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    rw_next    = rw_reg;
    armed_next = armed_reg | bus_idle;
    case (state_reg)
      IDLE: begin
        rw_next = 2'b00;
        if (!bus.Frame && armed_reg) begin
          armed_next = 1'b0;
          case (bus.CBE)
            4'b0110: begin
              rw_next    = 2'b01;
              state_next = DATA;
            end
            4'b0111: begin
              rw_next    = 2'b10;
              state_next = DATA;
            end
            default: begin
              rw_next    = 2'b11;
              state_next = IGNORE;
            end
          endcase
        end
      end
      DATA, IGNORE: begin
        if (bus_idle) begin
          rw_next    = 2'b00;
          state_next = IDLE;
        end
      end
      default: begin
        rw_next    = 2'b00;
        state_next = IDLE;
      end
    endcase
  end

  assign bus.rw = rw_reg;
  assign bus.RE = (state_reg == DATA) && (rw_reg == 2'b01) && !bus.Devsel && !bus.Irdy;
  assign bus.WE = (state_reg == DATA) && (rw_reg == 2'b10) && !bus.Devsel && !bus.Irdy;

endmodule

// File: tb/tb_pci_cmd_control.sv
// Directed bench for pci_cmd_control: one step per bus cycle, strobes checked
// before the rising edge and the latched command checked just after it.
module tb_pci_cmd_control;

  logic Clock;
  logic RST;
  int   n_checks;
  int   n_pass;

  pci_cmd_control_if bus ();

  pci_cmd_control dut (
    .Clock (Clock),
    .RST   (RST),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  // One bus cycle: drive at the falling edge, check strobes mid-cycle,
  // then check the command register after the rising edge.
  task automatic step(input string tag, input logic f, input logic i, input logic d,
                      input logic [3:0] cbe, input logic rst,
                      input logic exp_re, input logic exp_we, input logic [1:0] exp_rw);
    @(negedge Clock);
    bus.Frame  = f;
    bus.Irdy   = i;
    bus.Devsel = d;
    bus.CBE    = cbe;
    RST        = rst;
    #1;
    chk({tag, ".re"}, {3'b0, bus.RE}, {3'b0, exp_re});
    chk({tag, ".we"}, {3'b0, bus.WE}, {3'b0, exp_we});
    chk({tag, ".excl"}, {3'b0, bus.RE & bus.WE}, 4'b0);
    @(posedge Clock);
    #1;
    chk({tag, ".rw"}, {2'b0, bus.rw}, {2'b0, exp_rw});
    $display("step %-10s F=%b I=%b D=%b CBE=%h RST=%b -> RE=%b WE=%b rw=%b",
             tag, f, i, d, cbe, rst, exp_re, exp_we, bus.rw);
  endtask

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    RST        = 1'b1;
    bus.Frame  = 1'b1;
    bus.Irdy   = 1'b1;
    bus.Devsel = 1'b1;
    bus.CBE    = 4'h0;
    repeat (2) @(posedge Clock);

    step("reset",    1,1,1,4'h0,1, 0,0,2'b00);
    step("idle",     1,1,1,4'h0,0, 0,0,2'b00);

    // write burst: 4 strobed data phases
    step("wr.addr",  0,1,1,4'h7,0, 0,0,2'b10);
    step("wr.d1",    0,0,0,4'hF,0, 0,1,2'b10);
    step("wr.d2",    0,0,0,4'hF,0, 0,1,2'b10);
    step("wr.d3",    0,0,0,4'hF,0, 0,1,2'b10);
    step("wr.last",  1,0,0,4'hF,0, 0,1,2'b10);
    step("wr.end",   1,1,1,4'hF,0, 0,0,2'b00);

    // read burst, address phase with Irdy/Devsel already low
    step("rd.addr",  0,0,0,4'h6,0, 0,0,2'b01);
    step("rd.d1",    0,0,0,4'h0,0, 1,0,2'b01);
    step("rd.d2",    0,0,0,4'h0,0, 1,0,2'b01);
    step("rd.d3",    0,0,0,4'h0,0, 1,0,2'b01);
    step("rd.last",  1,0,0,4'h0,0, 1,0,2'b01);
    step("rd.end",   1,1,1,4'h0,0, 0,0,2'b00);

    // write with an initiator wait state; CBE changes ignored in data
    step("ws.addr",  0,1,1,4'h7,0, 0,0,2'b10);
    step("ws.d1",    0,0,0,4'h3,0, 0,1,2'b10);
    step("ws.wait",  0,1,0,4'h5,0, 0,0,2'b10);
    step("ws.d2",    0,0,0,4'h6,0, 0,1,2'b10);
    step("ws.last",  1,0,0,4'h2,0, 0,1,2'b10);
    step("ws.end",   1,1,1,4'h0,0, 0,0,2'b00);

    // unsupported command
    step("un.addr",  0,1,1,4'h2,0, 0,0,2'b11);
    step("un.d1",    0,0,0,4'hF,0, 0,0,2'b11);
    step("un.d2",    0,0,0,4'h7,0, 0,0,2'b11);
    step("un.last",  1,0,0,4'h6,0, 0,0,2'b11);
    step("un.end",   1,1,1,4'h0,0, 0,0,2'b00);

    // read not claimed by any target
    step("nc.addr",  0,1,1,4'h6,0, 0,0,2'b01);
    step("nc.d1",    0,0,1,4'h0,0, 0,0,2'b01);
    step("nc.last",  1,0,1,4'h0,0, 0,0,2'b01);
    step("nc.end",   1,1,1,4'h0,0, 0,0,2'b00);

    // reset in write data phase 2; leftover transaction must be ignored
    step("rs.addr",  0,1,1,4'h7,0, 0,0,2'b10);
    step("rs.d1",    0,0,0,4'hF,0, 0,1,2'b10);
    step("rs.d2",    0,0,0,4'hF,1, 0,1,2'b00);
    step("rs.stale1",0,0,0,4'h7,0, 0,0,2'b00);
    step("rs.stale2",0,0,0,4'h6,0, 0,0,2'b00);
    step("rs.slast", 1,0,0,4'h0,0, 0,0,2'b00);
    step("rs.idle",  1,1,1,4'h0,0, 0,0,2'b00);
    step("rs.addr2", 0,1,1,4'h7,0, 0,0,2'b10);
    step("rs.d",     0,0,0,4'hF,0, 0,1,2'b10);
    step("rs.last",  1,0,0,4'hF,0, 0,1,2'b10);
    step("rs.end",   1,1,1,4'h0,0, 0,0,2'b00);

    // back-to-back: write end edge is the only idle edge before the read
    step("bb.waddr", 0,1,1,4'h7,0, 0,0,2'b10);
    step("bb.wd",    0,0,0,4'hF,0, 0,1,2'b10);
    step("bb.wlast", 1,0,0,4'hF,0, 0,1,2'b10);
    step("bb.wend",  1,1,1,4'h0,0, 0,0,2'b00);
    step("bb.raddr", 0,1,1,4'h6,0, 0,0,2'b01);
    step("bb.rd",    0,0,0,4'h0,0, 1,0,2'b01);
    step("bb.rlast", 1,0,0,4'h0,0, 1,0,2'b01);
    step("bb.rend",  1,1,1,4'h0,0, 0,0,2'b00);
    step("final",    1,1,1,4'h0,0, 0,0,2'b00);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
